// File: rtl/sig_cmp_pkg.sv
// -----------------------------------------------------------------------------
// sig_cmp_pkg
// Shared definitions for the signature compare monitor: the monitor state
// encoding and the width of the free-running cycle stamp.
// -----------------------------------------------------------------------------
package sig_cmp_pkg;

  // Width of the cycle counter and of the first-mismatch cycle stamp.
  localparam int CYC_W = 32;

  // Monitor state. The encoding is visible on state_o, so it must stay fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FAILED = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/cmp_delay_line.sv
// -----------------------------------------------------------------------------
// cmp_delay_line
// Delays one channel of golden data and its valid flag by DEPTH clock cycles.
// DEPTH = 0 makes the block a plain wire.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset (clears data and valids)
//   clear_i  synchronous clear of the valid bits only
//   data_i   golden sample in
//   vld_i    golden sample valid in
//   data_o   golden sample, DEPTH cycles later
//   vld_o    matching valid, DEPTH cycles later
// -----------------------------------------------------------------------------
module cmp_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);

  if (DEPTH == 0) begin : g_wire
    // Control inputs have no function without storage.
    logic unused_ctl;
    assign unused_ctl = ^{clk_i, rst_ni, clear_i};
    assign data_o     = data_i;
    assign vld_o      = vld_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        // Data keeps shifting on clear; only the valids are dropped so that
        // nothing already in flight can be compared after a re-arm.
        data_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
        if (clear_i) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= vld_i;
          for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
        end
      end
    end

    assign data_o = data_q[DEPTH-1];
    assign vld_o  = vld_q[DEPTH-1];
  end

endmodule

// File: rtl/sig_compare_monitor.sv
// -----------------------------------------------------------------------------
// sig_compare_monitor
// Compares NCH channels of DUT data against golden data (delayed by LATENCY
// cycles), counts masked mismatches per channel, records the first mismatch
// and moves IDLE -> ARMED -> FAILED once THRESH mismatches have been seen.
//
// Input qualification: there is no backpressure. A golden sample on channel c
// takes part in a compare only when gold_vld_i[c] was high in the cycle it was
// presented; the DUT value is taken in the cycle that sample leaves the delay
// line. Every output is registered.
//
// Ports:
//   clk_i         clock (rising edge)
//   rst_ni        asynchronous active-low reset
//   arm_i         IDLE -> ARMED
//   clear_i       synchronous clear of everything, back to IDLE (beats arm_i)
//   dut_i         DUT values, channel c at [c*WIDTH +: WIDTH]
//   gold_i        golden values, same packing
//   gold_vld_i    golden valid per channel
//   mask_i        bit compare enable, shared by all channels
//   state_o       current state (IDLE=0, ARMED=1, FAILED=2)
//   err_o         one-cycle mismatch pulse per channel
//   fail_o        sticky failure flag, high in FAILED
//   mis_cnt_o     saturating mismatch counts, channel c at [c*CNT_W +: CNT_W]
//   first_ch_o    channel of the first mismatch (lowest index on ties)
//   first_cyc_o   cycle stamp of the first mismatch
//   first_dut_o   DUT value of the first mismatch
//   first_gold_o  golden value of the first mismatch
// -----------------------------------------------------------------------------
module sig_compare_monitor
  import sig_cmp_pkg::*;
#(
  parameter int NCH     = 1,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16,
  parameter int THRESH  = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    arm_i,
  input  logic                                    clear_i,
  input  logic [NCH*WIDTH-1:0]                    dut_i,
  input  logic [NCH*WIDTH-1:0]                    gold_i,
  input  logic [NCH-1:0]                          gold_vld_i,
  input  logic [WIDTH-1:0]                        mask_i,
  output logic [1:0]                              state_o,
  output logic [NCH-1:0]                          err_o,
  output logic                                    fail_o,
  output logic [NCH*CNT_W-1:0]                    mis_cnt_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_ch_o,
  output logic [CYC_W-1:0]                        first_cyc_o,
  output logic [WIDTH-1:0]                        first_dut_o,
  output logic [WIDTH-1:0]                        first_gold_o
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  // Wide enough for NCH (<=16) saturated counters and for any positive THRESH.
  localparam int SUM_W = (CNT_W + 5 > 33) ? CNT_W + 5 : 33;
  localparam logic [SUM_W-1:0] THRESH_V = SUM_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CYC_W-1:0] CYC_MAX  = '1;

  cmp_state_e           state_q;
  logic                 fail_q;
  logic [NCH-1:0]       err_q;
  logic [CNT_W-1:0]     cnt_q   [NCH];
  logic [CNT_W-1:0]     cnt_nxt [NCH];
  logic [SUM_W-1:0]     sum_nxt;
  logic [CYC_W-1:0]     cyc_q;
  logic                 cap_q;
  logic [CH_W-1:0]      first_ch_q;
  logic [CYC_W-1:0]     first_cyc_q;
  logic [WIDTH-1:0]     first_dut_q;
  logic [WIDTH-1:0]     first_gold_q;

  logic [NCH*WIDTH-1:0] gold_d;
  logic [NCH-1:0]       vld_d;
  logic [NCH-1:0]       mis;
  logic [CH_W-1:0]      pick_ch;
  logic [WIDTH-1:0]     pick_dut;
  logic [WIDTH-1:0]     pick_gold;

  // Golden delay line, one per channel.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    cmp_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (LATENCY)
    ) u_dly (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .data_i  (gold_i[c*WIDTH +: WIDTH]),
      .vld_i   (gold_vld_i[c]),
      .data_o  (gold_d[c*WIDTH +: WIDTH]),
      .vld_o   (vld_d[c])
    );
  end

  // Per-channel compare. The case-inequality makes an unknown DUT bit in an
  // enabled position count as a mismatch in simulation instead of vanishing.
  always_comb begin
    mis = '0;
    for (int c = 0; c < NCH; c++) begin
      if ((state_q != ST_IDLE) && vld_d[c]) begin
        mis[c] = (((dut_i[c*WIDTH +: WIDTH] ^ gold_d[c*WIDTH +: WIDTH]) & mask_i) !== '0);
      end
    end
  end

  // Saturating next counts, and their sum, so the threshold sees the mismatches
  // of the current cycle.
  always_comb begin
    sum_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      cnt_nxt[c] = cnt_q[c];
      if (mis[c] && (cnt_q[c] != CNT_MAX)) cnt_nxt[c] = cnt_q[c] + CNT_W'(1);
      sum_nxt = sum_nxt + SUM_W'(cnt_nxt[c]);
    end
  end

  // Lowest-index mismatching channel: scan downwards so the last hit wins.
  always_comb begin
    pick_ch   = '0;
    pick_dut  = '0;
    pick_gold = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (mis[c]) begin
        pick_ch   = CH_W'(c);
        pick_dut  = dut_i[c*WIDTH +: WIDTH];
        pick_gold = gold_d[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      fail_q       <= 1'b0;
      err_q        <= '0;
      cyc_q        <= '0;
      cap_q        <= 1'b0;
      first_ch_q   <= '0;
      first_cyc_q  <= '0;
      first_dut_q  <= '0;
      first_gold_q <= '0;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else if (clear_i) begin
      state_q      <= ST_IDLE;
      fail_q       <= 1'b0;
      err_q        <= '0;
      cyc_q        <= '0;
      cap_q        <= 1'b0;
      first_ch_q   <= '0;
      first_cyc_q  <= '0;
      first_dut_q  <= '0;
      first_gold_q <= '0;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else begin
      err_q <= mis;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_nxt[c];

      // The stamp is the cycle count of the mismatching cycle itself.
      if (!cap_q && (|mis)) begin
        cap_q        <= 1'b1;
        first_ch_q   <= pick_ch;
        first_cyc_q  <= cyc_q;
        first_dut_q  <= pick_dut;
        first_gold_q <= pick_gold;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            state_q <= ST_ARMED;
            cyc_q   <= '0;
          end
        end
        ST_ARMED: begin
          if (cyc_q != CYC_MAX) cyc_q <= cyc_q + CYC_W'(1);
          if (sum_nxt >= THRESH_V) begin
            state_q <= ST_FAILED;
            fail_q  <= 1'b1;
          end
        end
        ST_FAILED: begin
          if (cyc_q != CYC_MAX) cyc_q <= cyc_q + CYC_W'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          fail_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mis_cnt_o = '0;
    for (int c = 0; c < NCH; c++) mis_cnt_o[c*CNT_W +: CNT_W] = cnt_q[c];
  end

  assign state_o      = state_q;
  assign err_o        = err_q;
  assign fail_o       = fail_q;
  assign first_ch_o   = first_ch_q;
  assign first_cyc_o  = first_cyc_q;
  assign first_dut_o  = first_dut_q;
  assign first_gold_o = first_gold_q;

endmodule

// File: tb/tb_sig_compare_monitor.sv
// -----------------------------------------------------------------------------
// tb_sig_compare_monitor
// Instance A: NCH=4, LATENCY=2, CNT_W=3, THRESH=3, checked every cycle against
// a queue-based behavioural model plus literal spot checks.
// Instance B: NCH=1, LATENCY=0, CNT_W=2, THRESH=100, literal checks only.
// -----------------------------------------------------------------------------
module tb_sig_compare_monitor;

  localparam int W      = 8;
  localparam int A_NCH  = 4;
  localparam int A_LAT  = 2;
  localparam int A_CNTW = 3;
  localparam int A_TH   = 3;
  localparam int B_CNTW = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic                    arm_a, clear_a;
  logic [A_NCH*W-1:0]      dut_a, gold_a;
  logic [A_NCH-1:0]        vld_a;
  logic [W-1:0]            mask_a;
  logic [1:0]              state_a;
  logic [A_NCH-1:0]        err_a;
  logic                    fail_a;
  logic [A_NCH*A_CNTW-1:0] cnt_a;
  logic [1:0]              fch_a;
  logic [31:0]             fcyc_a;
  logic [W-1:0]            fdut_a, fgold_a;

  sig_compare_monitor #(
    .NCH(A_NCH), .WIDTH(W), .LATENCY(A_LAT), .CNT_W(A_CNTW), .THRESH(A_TH)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm_a), .clear_i(clear_a),
    .dut_i(dut_a), .gold_i(gold_a), .gold_vld_i(vld_a), .mask_i(mask_a),
    .state_o(state_a), .err_o(err_a), .fail_o(fail_a), .mis_cnt_o(cnt_a),
    .first_ch_o(fch_a), .first_cyc_o(fcyc_a), .first_dut_o(fdut_a),
    .first_gold_o(fgold_a)
  );

  // ---------------- instance B ----------------
  logic              arm_b, clear_b;
  logic [W-1:0]      dut_b, gold_b;
  logic [0:0]        vld_b;
  logic [W-1:0]      mask_b;
  logic [1:0]        state_b;
  logic [0:0]        err_b;
  logic              fail_b;
  logic [B_CNTW-1:0] cnt_b;
  logic [0:0]        fch_b;
  logic [31:0]       fcyc_b;
  logic [W-1:0]      fdut_b, fgold_b;

  sig_compare_monitor #(
    .NCH(1), .WIDTH(W), .LATENCY(0), .CNT_W(B_CNTW), .THRESH(100)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm_b), .clear_i(clear_b),
    .dut_i(dut_b), .gold_i(gold_b), .gold_vld_i(vld_b), .mask_i(mask_b),
    .state_o(state_b), .err_o(err_b), .fail_o(fail_b), .mis_cnt_o(cnt_b),
    .first_ch_o(fch_b), .first_cyc_o(fcyc_b), .first_dut_o(fdut_b),
    .first_gold_o(fgold_b)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of instance A ----------------
  typedef struct {
    logic [A_NCH*W-1:0] g;
    logic [A_NCH-1:0]   v;
  } smp_t;

  smp_t             dq[$];      // golden samples still in flight
  int               m_state;
  logic [A_NCH-1:0] m_err;
  int               m_cnt [A_NCH];
  longint           m_cyc;
  bit               m_cap;
  int               m_fch;
  longint           m_fcyc;
  logic [W-1:0]     m_fdut, m_fgold;

  task automatic model_clear();
    m_state = 0;
    m_err   = '0;
    m_cyc   = 0;
    m_cap   = 0;
    m_fch   = 0;
    m_fcyc  = 0;
    m_fdut  = '0;
    m_fgold = '0;
    for (int c = 0; c < A_NCH; c++) m_cnt[c] = 0;
  endtask

  task automatic model_reset();
    smp_t e;
    model_clear();
    dq.delete();
    e.g = '0;
    e.v = '0;
    for (int i = 0; i < A_LAT; i++) dq.push_back(e);
  endtask

  task automatic model_step();
    smp_t cur, del;
    logic [A_NCH-1:0] mis;
    int sum;
    cur.g = gold_a;
    cur.v = vld_a;
    if (A_LAT == 0) del = cur;
    else begin
      del = dq.pop_front();
      dq.push_back(cur);
    end
    mis = '0;
    for (int c = 0; c < A_NCH; c++)
      if (m_state != 0 && del.v[c] && ((dut_a[c*W +: W] ^ del.g[c*W +: W]) & mask_a) != 8'h00)
        mis[c] = 1'b1;
    if (clear_a) begin
      model_clear();
      foreach (dq[i]) dq[i].v = '0;
      return;
    end
    m_err = mis;
    sum = 0;
    for (int c = 0; c < A_NCH; c++) begin
      if (mis[c] && m_cnt[c] < (1 << A_CNTW) - 1) m_cnt[c]++;
      sum += m_cnt[c];
    end
    if (!m_cap && mis != '0) begin
      m_cap = 1;
      for (int c = 0; c < A_NCH; c++) if (mis[c]) begin m_fch = c; break; end
      m_fcyc  = m_cyc;
      m_fdut  = dut_a[m_fch*W +: W];
      m_fgold = del.g[m_fch*W +: W];
    end
    if (m_state == 0) begin
      if (arm_a) begin
        m_state = 1;
        m_cyc   = 0;
      end
    end else begin
      if (m_cyc < 64'h0000_0000_FFFF_FFFF) m_cyc++;
      if (m_state == 1 && sum >= A_TH) m_state = 2;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- compare process (every negedge) ----------------
  logic [A_NCH*A_CNTW-1:0] exp_cnt;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < A_NCH; c++) exp_cnt[c*A_CNTW +: A_CNTW] = A_CNTW'(m_cnt[c]);
      check("a_state",     64'(state_a), 64'(m_state));
      check("a_fail",      64'(fail_a),  64'(m_state == 2));
      check("a_err",       64'(err_a),   64'(m_err));
      check("a_cnt",       64'(cnt_a),   64'(exp_cnt));
      check("a_first_ch",  64'(fch_a),   64'(m_fch));
      check("a_first_cyc", 64'(fcyc_a),  64'(m_fcyc));
      check("a_first_dut", 64'(fdut_a),  64'(m_fdut));
      check("a_first_gld", 64'(fgold_a), 64'(m_fgold));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    arm_a   = 1'b0; clear_a = 1'b0; dut_a = '0; gold_a = '0; vld_a = '0; mask_a = 8'hFF;
    arm_b   = 1'b0; clear_b = 1'b0; dut_b = '0; gold_b = '0; vld_b = '0; mask_b = 8'hFF;
    chk_en  = 1'b1;
    step();
    step();
    check("rst_a_state", 64'(state_a), 64'd0);
    check("rst_b_cnt",   64'(cnt_b),   64'd0);
    rst_n = 1'b1;
    step();

    // A: golden ch1=3C, DUT ch1=3D two cycles later, arm at cycle 0.
    arm_a = 1'b1; vld_a = 4'b0010; gold_a = 32'h0000_3C00;
    step();
    arm_a = 1'b0; vld_a = '0; gold_a = '0;
    step();
    dut_a = 32'h0000_3D00;
    step();
    dut_a = '0;
    check("lit_err_ch1",     64'(err_a),   64'h2);
    check("lit_first_ch1",   64'(fch_a),   64'd1);
    check("lit_first_dut",   64'(fdut_a),  64'h3D);
    check("lit_first_gold",  64'(fgold_a), 64'h3C);
    check("lit_first_cyc",   64'(fcyc_a),  64'd1);
    check("lit_armed_below", 64'(fail_a),  64'd0);

    // A: clear together with arm -> IDLE, outputs zero.
    clear_a = 1'b1; arm_a = 1'b1;
    step();
    clear_a = 1'b0; arm_a = 1'b0;
    check("lit_clr_state", 64'(state_a), 64'd0);
    check("lit_clr_cnt",   64'(cnt_a),   64'd0);
    check("lit_clr_first", 64'({fch_a, fcyc_a, fdut_a, fgold_a}), 64'd0);

    // A: ch2 and ch3 mismatch in the same first cycle -> lowest index.
    arm_a = 1'b1; vld_a = 4'b1100; gold_a = '0;
    step();
    arm_a = 1'b0; vld_a = '0;
    step();
    dut_a = 32'h8001_0000;
    step();
    dut_a = '0;
    check("lit_tie_first_ch", 64'(fch_a),   64'd2);
    check("lit_tie_err",      64'(err_a),   64'hC);
    check("lit_tie_state",    64'(state_a), 64'd1);
    // One more mismatch reaches THRESH=3.
    vld_a = 4'b0001;
    step();
    vld_a = '0;
    step();
    dut_a = 32'h0000_00FF;
    step();
    dut_a = '0;
    check("lit_thresh_state", 64'(state_a), 64'd2);
    check("lit_thresh_fail",  64'(fail_a),  64'd1);
    check("lit_thresh_cnt",   64'(cnt_a),   64'h241);
    check("lit_thresh_ch",    64'(fch_a),   64'd2);
    clear_a = 1'b1; arm_a = 1'b1;
    step();
    clear_a = 1'b0; arm_a = 1'b0;
    check("lit_clr2_all", 64'({state_a, err_a, fail_a, cnt_a, fch_a, fdut_a, fgold_a}), 64'd0);

    // B: equal data for 10 cycles, then mask behaviour and saturation.
    arm_b = 1'b1;
    step();
    arm_b = 1'b0;
    check("b_armed", 64'(state_b), 64'd1);
    dut_b = 8'hA5; gold_b = 8'hA5; vld_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("b_eq_err", 64'(err_b), 64'd0);
    end
    check("b_eq_cnt",   64'(cnt_b),   64'd0);
    check("b_eq_state", 64'(state_b), 64'd1);
    mask_b = 8'hF0; dut_b = 8'h0F; gold_b = 8'h00;
    step();
    check("b_mask_err", 64'(err_b), 64'd0);
    check("b_mask_cnt", 64'(cnt_b), 64'd0);
    dut_b = 8'h10;
    step();
    check("b_mask_hit_err", 64'(err_b),  64'd1);
    check("b_mask_hit_cnt", 64'(cnt_b),  64'd1);
    check("b_first_cyc",    64'(fcyc_b), 64'd11);
    check("b_first_dut",    64'(fdut_b), 64'h10);
    mask_b = 8'hFF; dut_b = 8'h55; gold_b = 8'hAA;
    for (int i = 0; i < 4; i++) step();
    check("b_sat_cnt",   64'(cnt_b),   64'd3);
    check("b_sat_state", 64'(state_b), 64'd1);
    check("b_sat_fail",  64'(fail_b),  64'd0);
    vld_b = 1'b0; dut_b = '0; gold_b = '0;

    // A: randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      gold_a = $urandom;
      vld_a  = 4'($urandom_range(0, 15));
      dut_a  = gold_a;
      for (int c = 0; c < A_NCH; c++)
        if ($urandom_range(0, 5) == 0) dut_a[c*W +: W] = dut_a[c*W +: W] ^ 8'($urandom_range(1, 255));
      mask_a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      arm_a   = ($urandom_range(0, 7) == 0);
      clear_a = ($urandom_range(0, 39) == 0);
      step();
    end
    arm_a = 1'b0; clear_a = 1'b0; mask_a = 8'hFF;

    // A: clear with valid samples in flight, re-arm, drive into FAILED.
    clear_a = 1'b1; vld_a = 4'hF; gold_a = '0; dut_a = '0;
    step();
    clear_a = 1'b0; arm_a = 1'b1; dut_a = 32'h0101_0101;
    step();
    arm_a = 1'b0;
    for (int i = 0; i < 4; i++) step();
    vld_a = '0; dut_a = '0;
    step();
    step();
    check("lit_fail_state", 64'(state_a), 64'd2);
    check("lit_fail_cnt",   64'(cnt_a),   64'h6DB);
    check("lit_fail_cyc",   64'(fcyc_a),  64'd1);

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 64'(state_a), 64'd0);
    check("async_rst_fail",  64'(fail_a),  64'd0);
    check("async_rst_cnt",   64'(cnt_a),   64'd0);
    check("async_rst_b",     64'({state_b, cnt_b}), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
